rr_mux_arbiter: RTL and testbench

Parametrised N-channel arbitrated multiplexer with a registered output stage and valid/ready handshaking on every channel. It generalises the fixed 8-to-1 select mux: N_CHANNELS producers compete for one output, and a round-robin arbiter chooses the winner instead of an external selector. It sits in front of shared datapath resources such as the memory stage write port and the bus interface. It presents one registered, handshaked stream downstream.

---
 rtl/rr_mux_arbiter.sv | 99 +++++++++
 tb/tb_rr_mux_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// N-channel arbitrated mux with a registered, valid/ready handshaked output.
// Define RR_MUX_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority.
module rr_mux_arbiter #(
    parameter int N_BITS       = 32,
    parameter int N_CHANNELS   = 8,
    localparam int SEL_BITS    = $clog2(N_CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CHANNELS-1:0]        Valid_In,
    input  logic [N_CHANNELS*N_BITS-1:0] Data_In,
    output logic [N_CHANNELS-1:0]        Ready_Out,
    output logic [N_BITS-1:0]            Mux_Output,
    output logic                         Valid_Out,
    input  logic                         Ready_In,
    output logic [SEL_BITS-1:0]          Grant_Index
);

    logic [N_BITS-1:0]   r_data;
    logic [SEL_BITS-1:0] r_grant;
    logic                r_valid;

    logic                w_load_en;
    logic                w_found;
    logic                w_accept;
    logic [SEL_BITS-1:0] w_win;
    logic [SEL_BITS:0]   w_idx;
    logic [N_BITS-1:0]   w_data;

`ifdef RR_MUX_ROUND_ROBIN_EN
    logic [SEL_BITS-1:0] r_ptr;
`endif

    assign w_load_en = !r_valid || Ready_In;

    // Walk the channels from the start point; one spare bit absorbs the wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
`ifdef RR_MUX_ROUND_ROBIN_EN
            w_idx = {1'b0, r_ptr} + (SEL_BITS+1)'(k);
            if (w_idx >= (SEL_BITS+1)'(N_CHANNELS))
                w_idx = w_idx - (SEL_BITS+1)'(N_CHANNELS);
`else
            w_idx = (SEL_BITS+1)'(k);
`endif
            if (!w_found && Valid_In[w_idx[SEL_BITS-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[SEL_BITS-1:0];
            end
        end
    end

    assign w_accept = w_load_en && w_found && !reset;

    always_comb begin
        Ready_Out = '0;
        if (w_accept)
            Ready_Out[w_win] = 1'b1;
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (w_win == SEL_BITS'(i))
                w_data = Data_In[i*N_BITS +: N_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_data  <= w_data;
            r_grant <= w_win;
            r_valid <= 1'b1;
        end else if (r_valid && Ready_In) begin
            r_valid <= 1'b0;
        end
    end

`ifdef RR_MUX_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= '0;
        else if (w_accept)
            r_ptr <= (w_win == SEL_BITS'(N_CHANNELS-1)) ? '0 : w_win + 1'b1;
    end
`endif

    assign Mux_Output  = r_data;
    assign Grant_Index = r_grant;
    assign Valid_Out   = r_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter; expectations follow the
// arbitration mode selected by RR_MUX_ROUND_ROBIN_EN.
module tb_rr_mux_arbiter;

    localparam int NB = 32;
    localparam int NC = 8;
    localparam int SB = $clog2(NC);

    logic               clk = 1'b0;
    logic               reset;
    logic [NC-1:0]      Valid_In;
    logic [NC*NB-1:0]   Data_In;
    logic [NC-1:0]      Ready_Out;
    logic [NB-1:0]      Mux_Output;
    logic               Valid_Out;
    logic               Ready_In;
    logic [SB-1:0]      Grant_Index;

    int total = 0;
    int bad   = 0;

`ifdef RR_MUX_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    rr_mux_arbiter #(.N_BITS(NB), .N_CHANNELS(NC)) dut (
        .clk        (clk),
        .reset      (reset),
        .Valid_In   (Valid_In),
        .Data_In    (Data_In),
        .Ready_Out  (Ready_Out),
        .Mux_Output (Mux_Output),
        .Valid_Out  (Valid_Out),
        .Ready_In   (Ready_In),
        .Grant_Index(Grant_Index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic out_chk(input string tag, input int g);
        chk({tag, ".valid"}, 64'(Valid_Out), 64'd1);
        chk({tag, ".grant"}, 64'(Grant_Index), 64'(g));
        chk({tag, ".data"}, 64'(Mux_Output), 64'(32'h100 + g));
    endtask

    int g;
    int nxt;

    initial begin
        for (int i = 0; i < NC; i++)
            Data_In[i*NB +: NB] = 32'h100 + i;
        reset    = 1'b1;
        Valid_In = '1;
        Ready_In = 1'b1;

        // reset held two cycles with every channel requesting
        repeat (2) begin
            cyc();
            chk("rst.ready", 64'(Ready_Out), 64'd0);
        end
        chk("rst.valid", 64'(Valid_Out), 64'd0);
        chk("rst.data", 64'(Mux_Output), 64'd0);
        chk("rst.grant", 64'(Grant_Index), 64'd0);
        reset = 1'b0;
        #1;
        chk("rel.ready", 64'(Ready_Out), 64'h01);

        // all channels valid, downstream always ready
        for (int k = 0; k < 9; k++) begin
            cyc();
            g   = RR ? (k % NC) : 0;
            nxt = RR ? ((k + 1) % NC) : 0;
            out_chk($sformatf("order%0d", k), g);
            chk($sformatf("order%0d.ready", k), 64'(Ready_Out), 64'(1) << nxt);
        end

        // single requester at the top index
        Valid_In = 8'h80;
        for (int k = 0; k < 3; k++) begin
            cyc();
            out_chk($sformatf("top%0d", k), 7);
        end
        Valid_In = 8'h81;
        cyc();
        out_chk("wrap0", 0);
        cyc();
        out_chk("wrap1", RR ? 7 : 0);

        // backpressure with channels 2 and 5 waiting
        g        = RR ? 7 : 0;
        Ready_In = 1'b0;
        Valid_In = 8'h24;
        #1;
        chk("stall.ready0", 64'(Ready_Out), 64'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            out_chk($sformatf("stall%0d", k), g);
            chk($sformatf("stall%0d.ready", k), 64'(Ready_Out), 64'd0);
        end
        Ready_In = 1'b1;
        #1;
        chk("unstall.ready", 64'(Ready_Out), 64'h04);
        cyc();
        out_chk("unstall", 2);

        // two persistent requesters
        for (int k = 0; k < 4; k++) begin
            cyc();
            out_chk($sformatf("pair%0d", k), (RR && (k % 2 == 0)) ? 5 : 2);
        end

        // reset while stalled discards the pending word
        Ready_In = 1'b0;
        cyc();
        chk("pre_rst.valid", 64'(Valid_Out), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst.ready", 64'(Ready_Out), 64'd0);
        cyc();
        chk("mid_rst.valid", 64'(Valid_Out), 64'd0);
        chk("mid_rst.grant", 64'(Grant_Index), 64'd0);
        chk("mid_rst.data", 64'(Mux_Output), 64'd0);
        reset    = 1'b0;
        Valid_In = '0;
        Ready_In = 1'b1;
        #1;
        chk("idle.ready", 64'(Ready_Out), 64'd0);
        cyc();
        chk("idle.valid", 64'(Valid_Out), 64'd0);

        // one word, then drain with nothing to replace it
        Valid_In = 8'h10;
        cyc();
        out_chk("single", 4);
        Valid_In = '0;
        cyc();
        chk("drain.valid", 64'(Valid_Out), 64'd0);
        chk("drain.grant", 64'(Grant_Index), 64'd4);
        chk("drain.data", 64'(Mux_Output), 64'h104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
